// File: rtl/result_collector.sv
// Round-robin collector for the encrypter lanes. Each lane uses a four-phase
// data_ready/capture handshake, and captured words go through a show-ahead FIFO.
module result_collector #(
  parameter int ENCRYPTER_WIDTH = 32,
  parameter int NUM_LANES       = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 prog,
  input  logic [NUM_LANES*ENCRYPTER_WIDTH-1:0] data_in_e,
  input  logic [NUM_LANES-1:0]                 data_ready_in_e,
  output logic [NUM_LANES-1:0]                 capture_e,
  output logic [ENCRYPTER_WIDTH-1:0]           data_out,
  output logic                                 data_valid_out,
  input  logic                                 data_ack_in,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 fifo_full
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {SCAN, WAIT_DROP} state_t;

  state_t                     state_q, state_d;
  logic [LW-1:0]              ptr_q, ptr_d;
  logic [NUM_LANES-1:0]       cap_q, cap_d;
  logic [ENCRYPTER_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]              wr_q, rd_q;
  logic [CW-1:0]              count_q;

  logic                       lane_ready;
  logic [ENCRYPTER_WIDTH-1:0] lane_data;
  logic                       full;
  logic                       push;
  logic                       pop;

  assign lane_ready = data_ready_in_e[ptr_q];
  assign lane_data  = data_in_e[ptr_q*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
  assign full       = (count_q == CW'(FIFO_DEPTH));
  // The full test uses the occupancy before the edge, so a pop on the same edge cannot make room for a push.
  assign push       = (state_q == SCAN) && lane_ready && !full;
  assign pop        = (count_q != '0) && data_ack_in;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cap_d   = cap_q;
    case (state_q)
      SCAN: begin
        if (push) begin
          cap_d        = '0;
          cap_d[ptr_q] = 1'b1;
          state_d      = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!lane_ready) begin
          cap_d   = '0;
          ptr_d   = ptr_q + LW'(1);
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cap_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (prog) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      cap_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cap_q   <= cap_d;
      if (push) begin
        mem_q[wr_q] <= lane_data;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign capture_e      = cap_q;
  assign data_out       = mem_q[rd_q];
  assign data_valid_out = (count_q != '0);
  assign fifo_count     = count_q;
  assign fifo_full      = full;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: 4 lanes of 32 bits and an 8-entry FIFO.
module tb_result_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         prog;
  logic [127:0] data_in_e;
  logic [3:0]   data_ready_in_e;
  logic [3:0]   capture_e;
  logic [31:0]  data_out;
  logic         data_valid_out;
  logic         data_ack_in;
  logic [3:0]   fifo_count;
  logic         fifo_full;

  int checks   = 0;
  int failures = 0;

  // While set, step() toggles ack every cycle and scores each popped word against exp_next.
  logic        ack_toggle = 1'b0;
  logic [31:0] exp_next   = '0;

  result_collector #(
    .ENCRYPTER_WIDTH(32),
    .NUM_LANES(4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog(prog),
    .data_in_e(data_in_e),
    .data_ready_in_e(data_ready_in_e),
    .capture_e(capture_e),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .data_ack_in(data_ack_in),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (ack_toggle) begin
      if (data_valid_out && data_ack_in) begin
        chk("wrap_data", {32'h0, data_out}, {32'h0, exp_next});
        exp_next = exp_next + 1;
      end
    end
    @(posedge clk);
    #1;
    if (ack_toggle) begin
      data_ack_in = ~data_ack_in;
      chk("wrap_cnt_le8", {63'h0, fifo_count <= 4'd8}, 64'h1);
    end
  endtask

  task automatic set_lane(input int lane, input logic rdy, input logic [31:0] d);
    data_in_e[lane*32 +: 32] = d;
    data_ready_in_e[lane]    = rdy;
  endtask

  // A full handshake on one lane: raise ready, wait for capture, drop ready, see capture release.
  task automatic send(input int lane, input logic [31:0] d);
    int n;
    logic [3:0] onehot;
    n      = 0;
    onehot = 4'b0001 << lane;
    set_lane(lane, 1'b1, d);
    step();
    while (capture_e !== onehot && n < 60) begin
      step();
      n++;
    end
    chk("send_capture", {60'h0, capture_e}, {60'h0, onehot});
    data_ready_in_e[lane] = 1'b0;
    step();
    chk("send_release", {60'h0, capture_e}, 64'h0);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d);
    chk({tag, "_valid"}, {63'h0, data_valid_out}, 64'h1);
    chk(tag, {32'h0, data_out}, {32'h0, d});
    data_ack_in = 1'b1;
    step();
    data_ack_in = 1'b0;
  endtask

  task automatic pulse_prog();
    prog = 1'b1;
    step();
    prog = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    prog            = 1'b0;
    data_in_e       = '0;
    data_ready_in_e = '0;
    data_ack_in     = 1'b0;
    #23;
    chk("rst_capture", {60'h0, capture_e}, 64'h0);
    chk("rst_valid", {63'h0, data_valid_out}, 64'h0);
    chk("rst_count", {60'h0, fifo_count}, 64'h0);
    chk("rst_full", {63'h0, fifo_full}, 64'h0);
    chk("rst_data", {32'h0, data_out}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    step(); step(); step();
    chk("idle_capture", {60'h0, capture_e}, 64'h0);
    chk("idle_valid", {63'h0, data_valid_out}, 64'h0);
    chk("idle_count", {60'h0, fifo_count}, 64'h0);

    // Lanes become ready out of order; capture must still go 0, 1, 2, 3.
    set_lane(2, 1'b1, 32'hCAFEBABE);
    step(); step(); step(); step();
    chk("ooo_no_lane2", {60'h0, capture_e}, 64'h0);
    chk("ooo_count0", {60'h0, fifo_count}, 64'h0);
    set_lane(0, 1'b1, 32'h11111111);
    step();
    chk("ooo_cap0", {60'h0, capture_e}, 64'h1);
    chk("ooo_count1", {60'h0, fifo_count}, 64'h1);
    chk("ooo_head", {32'h0, data_out}, 64'h11111111);
    data_ready_in_e[0] = 1'b0;
    step();
    chk("ooo_rel0", {60'h0, capture_e}, 64'h0);
    step();
    chk("ooo_lane2_ignored", {60'h0, capture_e}, 64'h0);
    set_lane(1, 1'b1, 32'h22222222);
    set_lane(3, 1'b1, 32'h33333333);
    step();
    chk("ooo_cap1", {60'h0, capture_e}, 64'h2);
    data_ready_in_e[1] = 1'b0;
    step();
    step();
    chk("ooo_cap2", {60'h0, capture_e}, 64'h4);
    data_ready_in_e[2] = 1'b0;
    step();
    step();
    chk("ooo_cap3", {60'h0, capture_e}, 64'h8);
    data_ready_in_e[3] = 1'b0;
    step();
    chk("ooo_count4", {60'h0, fifo_count}, 64'h4);
    pop_expect("ooo_out0", 32'h11111111);
    pop_expect("ooo_out1", 32'h22222222);
    pop_expect("ooo_out2", 32'hCAFEBABE);
    pop_expect("ooo_out3", 32'h33333333);
    chk("ooo_empty", {63'h0, data_valid_out}, 64'h0);

    // Lane 0 keeps ready high for 3 cycles after capture.
    pulse_prog();
    set_lane(0, 1'b1, 32'hA0A0A0A0);
    step();
    chk("hs_cap", {60'h0, capture_e}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hs_hold", {60'h0, capture_e}, 64'h1);
      chk("hs_one_push", {60'h0, fifo_count}, 64'h1);
    end
    data_ready_in_e[0] = 1'b0;
    step();
    chk("hs_drop", {60'h0, capture_e}, 64'h0);
    set_lane(0, 1'b1, 32'hBADBAD00);
    set_lane(1, 1'b1, 32'hB1B1B1B1);
    step();
    chk("hs_ptr1", {60'h0, capture_e}, 64'h2);
    data_ready_in_e = '0;
    step();
    pop_expect("hs_out0", 32'hA0A0A0A0);
    pop_expect("hs_out1", 32'hB1B1B1B1);

    // Fill with no acks, hold a ninth word back, then free one slot.
    pulse_prog();
    for (int i = 0; i < 8; i++) send(i % 4, 32'h100 + i);
    chk("full_count", {60'h0, fifo_count}, 64'h8);
    chk("full_flag", {63'h0, fifo_full}, 64'h1);
    set_lane(0, 1'b1, 32'h108);
    step(); step(); step();
    chk("full_no_cap", {60'h0, capture_e}, 64'h0);
    chk("full_count_hold", {60'h0, fifo_count}, 64'h8);
    chk("full_head", {32'h0, data_out}, 64'h100);
    data_ack_in = 1'b1;
    step();
    data_ack_in = 1'b0;
    chk("full_pop_no_push", {60'h0, capture_e}, 64'h0);
    chk("full_count7", {60'h0, fifo_count}, 64'h7);
    step();
    chk("full_ninth_cap", {60'h0, capture_e}, 64'h1);
    chk("full_count8", {60'h0, fifo_count}, 64'h8);
    data_ready_in_e[0] = 1'b0;
    step();
    for (int i = 1; i < 9; i++) pop_expect("full_drain", 32'h100 + i);
    chk("full_empty", {60'h0, fifo_count}, 64'h0);

    // 20 words with ack toggling each cycle, so the FIFO pointers wrap.
    pulse_prog();
    exp_next    = '0;
    data_ack_in = 1'b1;
    ack_toggle  = 1'b1;
    for (int i = 0; i < 20; i++) send(i % 4, 32'(i));
    for (int n = 0; n < 100 && exp_next != 20; n++) step();
    ack_toggle  = 1'b0;
    data_ack_in = 1'b0;
    chk("wrap_all_out", {32'h0, exp_next}, 64'd20);
    chk("wrap_empty", {60'h0, fifo_count}, 64'h0);

    // prog asserted in WAIT_DROP with 3 words buffered.
    pulse_prog();
    send(0, 32'hD0D0D0D0);
    send(1, 32'hD1D1D1D1);
    set_lane(2, 1'b1, 32'hD2D2D2D2);
    step();
    chk("prog_pre_cap", {60'h0, capture_e}, 64'h4);
    chk("prog_pre_count", {60'h0, fifo_count}, 64'h3);
    pulse_prog();
    chk("prog_count", {60'h0, fifo_count}, 64'h0);
    chk("prog_capture", {60'h0, capture_e}, 64'h0);
    chk("prog_valid", {63'h0, data_valid_out}, 64'h0);
    step(); step();
    chk("prog_lane2_ignored", {60'h0, capture_e}, 64'h0);
    set_lane(0, 1'b1, 32'hE0E0E0E0);
    step();
    chk("prog_lane0_first", {60'h0, capture_e}, 64'h1);
    chk("prog_new_head", {32'h0, data_out}, 64'hE0E0E0E0);

    // Asynchronous reset between edges while a handshake is open.
    #3;
    reset = 1'b1;
    #1;
    chk("arst_capture", {60'h0, capture_e}, 64'h0);
    chk("arst_valid", {63'h0, data_valid_out}, 64'h0);
    chk("arst_count", {60'h0, fifo_count}, 64'h0);
    chk("arst_data", {32'h0, data_out}, 64'h0);
    data_ready_in_e = '0;
    @(negedge clk);
    reset = 1'b0;
    step(); step();
    chk("arst_idle", {60'h0, capture_e}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream neighbour of the encrypter array. Collects encrypted words from NUM_LANES encrypter lanes in strict round-robin order (lane 0, 1, …, NUM_LANES-1, 0, …), matching the parallelizer's dispatch order.
- Handshakes with each lane via data_ready / capture.
- Buffers words in an internal show-ahead FIFO and presents them as a single valid/ready output stream to the serializer/output stage.

Parameters:
- ENCRYPTER_WIDTH, 32, word width; equals the encrypter data width.
- NUM_LANES, 4, number of encrypter lanes; power of two, at least 2.
- FIFO_DEPTH, 8, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog  in  1  synchronous restart: clears the FIFO and the lane pointer.
- data_in_e  in  NUM_LANES*ENCRYPTER_WIDTH  lane data; lane i occupies bits [i*W +: W].
- data_ready_in_e  in  NUM_LANES  per-lane "result valid" level from each encrypter.
- capture_e  out  NUM_LANES  per-lane capture acknowledge; registered.
- data_out  out  ENCRYPTER_WIDTH  FIFO head word.
- data_valid_out  out  1  high when the FIFO is non-empty.
- data_ack_in  in  1  consumer ready; a pop occurs when data_valid_out && data_ack_in.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- fifo_full  out  1  high when fifo_count == FIFO_DEPTH.

Behaviour:

Reset (asynchronous, takes effect immediately):
- capture_e = 0, data_out = 0, data_valid_out = 0, fifo_count = 0, fifo_full = 0.
- Lane pointer ptr = 0; state = SCAN.

States:
- SCAN: watch lane ptr only; the other lanes' ready bits are ignored.
  - Capture condition: data_ready_in_e[ptr] = 1 and the FIFO is not full at that edge.
  - On that edge: push data_in_e lane ptr into the FIFO, set capture_e[ptr] = 1, go to WAIT_DROP.
  - If ready but the FIFO is full: stay in SCAN with capture_e = 0 and no push.
- WAIT_DROP: capture_e[ptr] stays high (four-phase handshake).
  - On the first edge where data_ready_in_e[ptr] = 0: capture_e[ptr] = 0, ptr = (ptr+1) mod NUM_LANES, go to SCAN.
  - No timeout; a lane stuck high holds the block in WAIT_DROP.
- At most one capture_e bit is ever high.

Latency and FIFO rules:
- Capture edge to data_valid_out high is one edge: the pushed word is visible after the capture edge if the FIFO was empty.
- Full check uses the occupancy before the edge. A pop on the same edge does not permit a push while full.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Pop when empty: impossible, since valid = 0.
- Read and write pointers wrap modulo FIFO_DEPTH.
- data_out is the head entry and only changes on a pop or a push into an empty FIFO; it holds while data_ack_in = 0.
- Data passes through unmodified; no arithmetic on data.

prog (sampled on the rising edge, highest priority after reset):
- FIFO emptied (count 0, valid 0); ptr = 0; capture_e = 0; state = SCAN.
- Any push or pop on the same edge is discarded.
- If prog is asserted in WAIT_DROP, the handshake is abandoned and the lane re-presents its data. That is acceptable because the encrypters are re-keyed on prog.

Reset mid-operation: identical to power-up; in-flight words are lost.

Test Plan:
- Reset and idle:
  - Assert reset asynchronously between edges → capture_e = 0, data_valid_out = 0, fifo_count = 0 immediately.
  - Release reset with no lane ready → outputs stay 0.
- Out-of-order readiness:
  - Stimulus: lane 2 ready with 0xCAFEBABE at cycle 1, lane 0 ready with 0x11111111 at cycle 5, then lanes 1 and 3 ready.
  - Required: lane 0 captured first, no capture on lane 2 before lanes 0 and 1; output order is lane0, lane1, lane2 (0xCAFEBABE), lane3.
- Four-phase handshake:
  - Lane 0 holds ready for 3 cycles after capture → capture_e[0] stays high until ready drops, ptr advances to 1 on the drop edge, exactly one FIFO push.
- Full and backpressure:
  - data_ack_in = 0, 8 words captured → fifo_full = 1, fifo_count = 8.
  - A 9th lane ready → capture_e stays 0.
  - One pop → 9th word captured on the next edge; output sequence intact.
- Wrap-around:
  - 20 words through 4 lanes with data_ack_in toggling 1/0 → the FIFO pointers wrap.
  - Output equals input order 0..19; fifo_count never exceeds 8.
- prog mid-operation:
  - Assert prog while in WAIT_DROP with 3 words buffered → next edge gives fifo_count = 0, capture_e = 0, ptr = 0.
  - The next capture comes from lane 0.
